gpio_ctrl_v2: RTL

//  Parametrised memory-mapped GPIO controller for the RISC-V SOC IO page: N pins,

---
 rtl/gpio_ctrl_v2_if.sv | 12 +
 rtl/gpio_ctrl_v2.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl_v2_if.sv
// IO-bus port bundle for gpio_ctrl_v2: select, word offset, write/read strobes and data.
interface gpio_ctrl_v2_if;
    logic        sel;
    logic [3:0]  reg_addr;
    logic        write_en;
    logic [31:0] wdata;
    logic        read_en;
    logic [31:0] rdata;

    modport master (output sel, reg_addr, write_en, wdata, read_en, input rdata);
    modport slave  (input sel, reg_addr, write_en, wdata, read_en, output rdata);
endinterface

// File: rtl/gpio_ctrl_v2.sv
// Memory-mapped GPIO controller: direction, atomic set/clr/toggle, synchronised inputs, edge IRQs.
// Optional per-pin input debounce is built when GPIO_DEBOUNCE_EN is defined.
module gpio_ctrl_v2 #(
    parameter int                  NUM_PINS        = 8,
    parameter int                  SYNC_STAGES     = 2,
    parameter logic [NUM_PINS-1:0] OUT_RESET       = '0,
    parameter int                  DEBOUNCE_CYCLES = 1200
) (
    input  logic                clk,
    input  logic                resetn,
    gpio_ctrl_v2_if.slave       bus,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq
);
    localparam logic [3:0] A_DATA_OUT = 4'd0;
    localparam logic [3:0] A_DIR      = 4'd1;
    localparam logic [3:0] A_DATA_IN  = 4'd2;
    localparam logic [3:0] A_SET      = 4'd3;
    localparam logic [3:0] A_CLR      = 4'd4;
    localparam logic [3:0] A_TOGGLE   = 4'd5;
    localparam logic [3:0] A_RISE_EN  = 4'd6;
    localparam logic [3:0] A_FALL_EN  = 4'd7;
    localparam logic [3:0] A_STATUS   = 4'd8;

    typedef logic [NUM_PINS-1:0] pins_t;

    pins_t       data_out_q, data_out_d;
    pins_t       dir_q, dir_d;
    pins_t       rise_en_q, rise_en_d;
    pins_t       fall_en_q, fall_en_d;
    pins_t       status_q, status_d;
    pins_t       prev_q;
    pins_t       filt;
    pins_t       sync_q [SYNC_STAGES];
    logic [31:0] rdata_q, rdata_d;

    logic  wr, rd;
    pins_t wbits, rise, fall, set_ev;
    logic  unused_wdata;

    assign wr           = bus.sel & bus.write_en;
    assign rd           = bus.sel & bus.read_en;
    assign wbits        = bus.wdata[NUM_PINS-1:0];
    assign unused_wdata = ^bus.wdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q [NUM_PINS];
    pins_t         filt_q;

    // filt follows the synchroniser only after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk) begin
        if (!resetn) begin
            filt_q <= '0;
            for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PINS; i++) begin
                if (sync_q[SYNC_STAGES-1][i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    filt_q[i] <= sync_q[SYNC_STAGES-1][i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign filt = filt_q;
`else
    localparam int unused_deb_cycles = DEBOUNCE_CYCLES;

    assign filt = sync_q[SYNC_STAGES-1];
`endif

    assign rise   = filt & ~prev_q;
    assign fall   = ~filt & prev_q;
    assign set_ev = (rise & rise_en_q) | (fall & fall_en_q);

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        status_d   = status_q | set_ev;
        rdata_d    = rdata_q;

        if (wr) begin
            case (bus.reg_addr)
                A_DATA_OUT: data_out_d = wbits;
                A_DIR:      dir_d      = wbits;
                A_SET:      data_out_d = data_out_q | wbits;
                A_CLR:      data_out_d = data_out_q & ~wbits;
                A_TOGGLE:   data_out_d = data_out_q ^ wbits;
                A_RISE_EN:  rise_en_d  = wbits;
                A_FALL_EN:  fall_en_d  = wbits;
                // a new edge in the same cycle as the W1C keeps its bit set
                A_STATUS:   status_d   = (status_q & ~wbits) | set_ev;
                default:    ;
            endcase
        end

        if (rd) begin
            case (bus.reg_addr)
                A_DATA_OUT: rdata_d = 32'(data_out_q);
                A_DIR:      rdata_d = 32'(dir_q);
                A_DATA_IN:  rdata_d = 32'(filt);
                A_RISE_EN:  rdata_d = 32'(rise_en_q);
                A_FALL_EN:  rdata_d = 32'(fall_en_q);
                A_STATUS:   rdata_d = 32'(status_q);
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_out_q <= OUT_RESET;
            dir_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            prev_q     <= '0;
            rdata_q    <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            prev_q     <= filt;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign gpio_out  = data_out_q;
    assign gpio_oe   = dir_q;
    assign irq       = |status_q;
endmodule
